// File: rtl/memory_arbiter_pkg.sv
// Shared widths, FSM state encoding and request record for the two-port
// MemoryUnit arbiter.
package memory_arbiter_pkg;

    localparam int ADDR_W          = 27;
    localparam int DATA_W          = 32;
    localparam int DEFAULT_TIMEOUT = 4096;
    localparam int DEFAULT_TO_W    = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic              we;
    } req_t;

endpackage

// File: rtl/mem_req_port.sv
// One requester slot: arm/capture latch, pending flag, and the registered
// done pulse / read data returned to the requester.
module mem_req_port
    import memory_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              we,
    input  logic              complete,
    input  logic [DATA_W-1:0] complete_q,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] q,
    output req_t              req
);

    logic              armed_q, armed_d;
    logic              pending_q, pending_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] q_q, q_d;
    req_t              req_q, req_d;
    logic              capture;

    always_comb begin
        capture   = armed_q && !pending_q && start;
        armed_d   = armed_q;
        pending_d = pending_q;
        req_d     = req_q;
        done_d    = complete;
        q_d       = q_q;
        // Disarm on capture so a start level held past done cannot re-issue.
        if (capture) begin
            armed_d       = 1'b0;
            pending_d     = 1'b1;
            req_d.address = address;
            req_d.data    = data;
            req_d.we      = we;
        end else if (!start) begin
            armed_d = 1'b1;
        end
        if (complete) begin
            pending_d = 1'b0;
            q_d       = complete_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q   <= 1'b1;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            q_q       <= '0;
            req_q     <= '0;
        end else begin
            armed_q   <= armed_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            q_q       <= q_d;
            req_q     <= req_d;
        end
    end

    assign busy = pending_q;
    assign done = done_q;
    assign q    = q_q;
    assign req  = req_q;

endmodule

// File: rtl/memory_arbiter.sv
// Shares one MemoryUnit port between CPU (port 0) and DMA (port 1): arbitration,
// start/busy sequencing with a per-phase timeout, and done/q return.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int TO_W       = DEFAULT_TO_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              r0_we,
    input  logic              r0_start,
    output logic              r0_busy,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_q,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_data,
    input  logic              r1_we,
    input  logic              r1_start,
    output logic              r1_busy,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_q,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data,
    output logic              m_we,
    output logic              m_start,
    input  logic              m_busy,
    input  logic [DATA_W-1:0] m_q,
    input  logic              m_init_done,
    output logic              timeout_err,
    output state_e            dbg_state
);

    // Handshake: m_start rises on grant and stays high until MemoryUnit has
    // raised and then dropped m_busy; it falls on the same edge the FSM enters
    // DONE, so the MemoryUnit's next negedge sample never sees a stale start.

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              prio_q, prio_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              to_flag_q, to_flag_d;
    logic              terr_q, terr_d;
    logic              win, expired;
    logic              cpl0, cpl1;
    logic [DATA_W-1:0] cpl_q;
    req_t              req0, req1, sel;

    assign cpl0  = (state_q == ST_DONE) && !grant_q;
    assign cpl1  = (state_q == ST_DONE) && grant_q;
    assign cpl_q = to_flag_q ? '0 : m_q;

    mem_req_port u_port0 (
        .clk(clk), .reset(reset), .start(r0_start), .address(r0_address),
        .data(r0_data), .we(r0_we), .complete(cpl0), .complete_q(cpl_q),
        .busy(r0_busy), .done(r0_done), .q(r0_q), .req(req0)
    );

    mem_req_port u_port1 (
        .clk(clk), .reset(reset), .start(r1_start), .address(r1_address),
        .data(r1_data), .we(r1_we), .complete(cpl1), .complete_q(cpl_q),
        .busy(r1_busy), .done(r1_done), .q(r1_q), .req(req1)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        to_flag_d = to_flag_q;
        terr_d    = 1'b0;
        win       = 1'b0;
        expired   = (cnt_q == TO_W'(TIMEOUT - 1));
        case (state_q)
            ST_IDLE: begin
                if (m_init_done && (r0_busy || r1_busy)) begin
                    if (r0_busy && r1_busy) win = FIXED_PRIO ? 1'b0 : prio_q;
                    else                    win = r1_busy;
                    grant_d   = win;
                    prio_d    = ~win;
                    to_flag_d = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (expired) begin
                    to_flag_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (m_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (expired) begin
                    to_flag_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (!m_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                terr_d  = to_flag_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The timeout window restarts on every state entry.
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == ST_ISSUE || state_q == ST_WAIT)
            cnt_d = cnt_q + TO_W'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            to_flag_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            to_flag_q <= to_flag_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        sel       = grant_q ? req1 : req0;
        m_start   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        m_address = '0;
        m_data    = '0;
        m_we      = 1'b0;
        if (state_q != ST_IDLE) begin
            m_address = sel.address;
            m_data    = sel.data;
            m_we      = sel.we;
        end
    end

    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

endmodule
